// File: rtl/mem_bus_ctrl.sv
// Registered memory/bus controller: word RAM plus an MMIO page (LED, cycle counter).
// Define MEM_BUS_BUSERR_EN to add the sticky bus-error register and the oBusErr output.
module mem_bus_ctrl #(
    parameter int          ADDR_W      = 12,
    parameter logic [31:0] MMIO_BASE   = 32'h0000F000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        iClk,
    input  logic        nRst,
    input  logic [31:0] iMemAddr,
    input  logic [31:0] iMemData,
    output logic [31:0] oMemData,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    output logic        oMemReady,
    output logic [7:0]  oLed,
`ifdef MEM_BUS_BUSERR_EN
    output logic        oBusErr,
`endif
    output logic [1:0]  oFsmState
);

    // Handshake: a strobe sampled high in IDLE starts one transaction; oMemReady
    // pulses for exactly one cycle with oMemData valid, and the CPU must drop or
    // change its request on the edge after that pulse.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic        first_q, first_d;
    logic [31:2] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        ready_q, ready_d;
    logic [7:0]  led_q, led_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] ram_rd_q;
    logic [31:0] err_rd;

    logic [31:0] ram [0:(1<<ADDR_W)-1];

    logic              hit_ram, hit_mmio, hit_led, hit_cnt, hit_err, mapped;
    logic [9:0]        mmio_off;
    logic [ADDR_W-1:0] ram_idx;
    logic [31:0]       rd_val;
    logic              ram_we, ram_re;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^iMemAddr[1:0];

    assign hit_ram  = (addr_q[31:ADDR_W+2] == '0);
    assign hit_mmio = (addr_q[31:12] == MMIO_BASE[31:12]);
    assign mmio_off = addr_q[11:2];
    assign ram_idx  = addr_q[ADDR_W+1:2];
    assign hit_led  = !hit_ram && hit_mmio && (mmio_off == 10'd0);
    assign hit_cnt  = !hit_ram && hit_mmio && (mmio_off == 10'd1);

`ifdef MEM_BUS_BUSERR_EN
    logic [31:0] err_q, err_d;
    assign hit_err = !hit_ram && hit_mmio && (mmio_off == 10'd2);
    assign err_rd  = err_q;
    assign oBusErr = err_q[0];
`else
    assign hit_err = 1'b0;
    assign err_rd  = '0;
`endif

    assign mapped = hit_ram || hit_led || hit_cnt || hit_err;

    // The RAM read is launched on the IDLE->ACCESS edge so its data is ready in
    // the first ACCESS cycle without adding latency.
    assign ram_re = (state_q == IDLE) && (iMemRead || iMemWrite);
    assign ram_we = (state_q == ACCESS) && first_q && is_wr_q && hit_ram;

    always_comb begin
        rd_val = '0;
        if (!is_wr_q) begin
            if (hit_ram)      rd_val = ram_rd_q;
            else if (hit_led) rd_val = {24'b0, led_q};
            else if (hit_cnt) rd_val = cnt_q;
            else if (hit_err) rd_val = err_rd;
        end
    end

    always_ff @(posedge iClk) begin
        if (ram_we) ram[ram_idx] <= wdata_q;
        if (ram_re) ram_rd_q <= ram[iMemAddr[ADDR_W+1:2]];
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        first_d    = first_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_wr_d    = is_wr_q;
        rdata_d    = rdata_q;
        mem_data_d = mem_data_q;
        ready_d    = 1'b0;
        led_d      = led_q;
        cnt_d      = cnt_q + 32'd1;
`ifdef MEM_BUS_BUSERR_EN
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                mem_data_d = '0;
                if (iMemWrite || iMemRead) begin
                    addr_d  = iMemAddr[31:2];
                    wdata_d = iMemData;
                    is_wr_d = iMemWrite;
                    wait_d  = 4'(WAIT_STATES);
                    first_d = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                first_d = 1'b0;
                if (first_q) begin
                    rdata_d = rd_val;
                    if (is_wr_q && hit_led) led_d = wdata_q[7:0];
`ifdef MEM_BUS_BUSERR_EN
                    if (is_wr_q && hit_err) err_d = '0;
                    if (!mapped)            err_d = {addr_q, 2'b01};
`endif
                end
                if (wait_q == 4'd0) begin
                    state_d    = DONE;
                    ready_d    = 1'b1;
                    mem_data_d = first_q ? rd_val : rdata_q;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            DONE: begin
                state_d    = IDLE;
                mem_data_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            first_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_wr_q    <= 1'b0;
            rdata_q    <= '0;
            mem_data_q <= '0;
            ready_q    <= 1'b0;
            led_q      <= '0;
            cnt_q      <= '0;
`ifdef MEM_BUS_BUSERR_EN
            err_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            first_q    <= first_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_wr_q    <= is_wr_d;
            rdata_q    <= rdata_d;
            mem_data_q <= mem_data_d;
            ready_q    <= ready_d;
            led_q      <= led_d;
            cnt_q      <= cnt_d;
`ifdef MEM_BUS_BUSERR_EN
            err_q      <= err_d;
`endif
        end
    end

    assign oMemData  = mem_data_q;
    assign oMemReady = ready_q;
    assign oLed      = led_q;
    assign oFsmState = state_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: one instance at WAIT_STATES=0 and one at WAIT_STATES=3
// sharing clock, reset, address and data, with separate request strobes.
module tb_mem_bus_ctrl;

    localparam int WS3 = 3;

    logic        clk, rst_n;
    logic [31:0] addr, wdata;
    logic        rd0, wr0, rd3, wr3;
    logic [31:0] d0, d3;
    logic        rdy0, rdy3;
    logic [7:0]  led0, led3;
    logic [1:0]  st0, st3;
`ifdef MEM_BUS_BUSERR_EN
    logic        berr0, berr3;
`endif

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] cyc_m;
    logic        prev_rdy;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic [7:0]  exp_led;
    } vec_t;
    vec_t vecs[$];

    mem_bus_ctrl #(.ADDR_W(12), .MMIO_BASE(32'h0000F000), .WAIT_STATES(0)) u_dut (
        .iClk(clk), .nRst(rst_n), .iMemAddr(addr), .iMemData(wdata),
        .oMemData(d0), .iMemRead(rd0), .iMemWrite(wr0), .oMemReady(rdy0),
        .oLed(led0),
`ifdef MEM_BUS_BUSERR_EN
        .oBusErr(berr0),
`endif
        .oFsmState(st0)
    );

    mem_bus_ctrl #(.ADDR_W(12), .MMIO_BASE(32'h0000F000), .WAIT_STATES(WS3)) u_dut_ws (
        .iClk(clk), .nRst(rst_n), .iMemAddr(addr), .iMemData(wdata),
        .oMemData(d3), .iMemRead(rd3), .iMemWrite(wr3), .oMemReady(rdy3),
        .oLed(led3),
`ifdef MEM_BUS_BUSERR_EN
        .oBusErr(berr3),
`endif
        .oFsmState(st3)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle count: zero in reset, +1 on every edge afterwards.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_m <= '0;
        else        cyc_m <= cyc_m + 32'd1;
    end

    // Scoreboard: every ready pulse pops one expected read value.
    always @(negedge clk) begin
        if (rst_n && (rdy0 || rdy3)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ready got_data=%08h exp=none", rdy0 ? d0 : d3);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if ((rdy0 ? d0 : d3) !== e) begin
                    failures++;
                    $display("FAIL read_data got=%08h exp=%08h", rdy0 ? d0 : d3, e);
                end
            end
            checks++;
            if (prev_rdy) begin
                failures++;
                $display("FAIL ready_width got=2+ cycles exp=1 cycle");
            end
        end
        prev_rdy = rst_n && (rdy0 || rdy3);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", name, got, exp);
        end
    endtask

    // Driver: one full transaction, request held until ready, latency measured
    // in edges after the sampling edge.
    task automatic bus_txn(input bit ws3, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp, input bit exp_cnt,
                           output logic [31:0] got, output int lat);
        bit seen;
        @(negedge clk);
        addr  = a;
        wdata = wd;
        if (ws3) begin rd3 = rd; wr3 = wr; end
        else     begin rd0 = rd; wr0 = wr; end
        exp_q.push_back(exp_cnt ? cyc_m + 32'd1 : exp);
        @(posedge clk);
        seen = 1'b0;
        lat  = 0;
        got  = '0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (ws3 ? rdy3 : rdy0) begin
                seen = 1'b1;
                lat  = k;
                got  = ws3 ? d3 : d0;
            end
        end
        rd0 = 1'b0; wr0 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;
        chk("latency", 32'(lat), ws3 ? 32'(2 + WS3) : 32'd2);
        if (!seen && exp_q.size() != 0) void'(exp_q.pop_back());
    endtask

    // Start a WAIT_STATES=3 transaction and hit reset k edges into ACCESS.
    task automatic abort_txn(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input int at_k);
        bit saw_rdy;
        @(negedge clk);
        addr = a; wdata = wd; rd3 = rd; wr3 = wr;
        @(posedge clk);
        repeat (at_k) @(negedge clk);
        rst_n = 1'b0;
        rd3 = 1'b0; wr3 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_state_idle", 32'(st3), 32'd0);
        saw_rdy = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rdy3) saw_rdy = 1'b1;
        end
        chk("abort_no_ready", 32'(saw_rdy), 32'd0);
    endtask

    logic [31:0] got, r1, r2;
    int lat;

    initial begin
        rst_n = 1'b0;
        addr = '0; wdata = '0;
        rd0 = 1'b0; wr0 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;
        prev_rdy = 1'b0;

        //            rd    wr    addr          wdata         exp           led
        vecs.push_back('{1'b0, 1'b1, 32'h00001000, 32'h00000002, 32'h00000000, 8'h00});
        vecs.push_back('{1'b0, 1'b1, 32'h00001004, 32'h00000001, 32'h00000000, 8'h00});
        vecs.push_back('{1'b1, 1'b0, 32'h00001000, 32'h0,        32'h00000002, 8'h00});
        vecs.push_back('{1'b1, 1'b0, 32'h00001004, 32'h0,        32'h00000001, 8'h00});
        vecs.push_back('{1'b1, 1'b0, 32'h00001002, 32'h0,        32'h00000002, 8'h00});
        vecs.push_back('{1'b0, 1'b1, 32'h0000F000, 32'hA5A5A5A5, 32'h00000000, 8'hA5});
        vecs.push_back('{1'b1, 1'b0, 32'h0000F000, 32'h0,        32'h000000A5, 8'hA5});
        vecs.push_back('{1'b1, 1'b1, 32'h00000008, 32'h12345678, 32'h00000000, 8'hA5});
        vecs.push_back('{1'b1, 1'b0, 32'h00000008, 32'h0,        32'h12345678, 8'hA5});
        vecs.push_back('{1'b1, 1'b0, 32'h00008000, 32'h0,        32'h00000000, 8'hA5});
        vecs.push_back('{1'b0, 1'b1, 32'h00003FFC, 32'hDEADBEEF, 32'h00000000, 8'hA5});
        vecs.push_back('{1'b0, 1'b1, 32'h00000000, 32'hABCD0123, 32'h00000000, 8'hA5});
        vecs.push_back('{1'b1, 1'b0, 32'h00003FFC, 32'h0,        32'hDEADBEEF, 8'hA5});
        vecs.push_back('{1'b1, 1'b0, 32'h00000000, 32'h0,        32'hABCD0123, 8'hA5});
        vecs.push_back('{1'b1, 1'b0, 32'h00004000, 32'h0,        32'h00000000, 8'hA5});
        vecs.push_back('{1'b0, 1'b1, 32'h00004000, 32'h55555555, 32'h00000000, 8'hA5});
        vecs.push_back('{1'b1, 1'b0, 32'h0000F00C, 32'h0,        32'h00000000, 8'hA5});
        vecs.push_back('{1'b0, 1'b1, 32'h0000F004, 32'hFFFFFFFF, 32'h00000000, 8'hA5});
        vecs.push_back('{1'b0, 1'b1, 32'h0000F010, 32'h000000FF, 32'h00000000, 8'hA5});

        repeat (3) @(negedge clk);
        chk("reset_data", d0, 32'h0);
        chk("reset_ready", 32'(rdy0), 32'h0);
        chk("reset_led", 32'(led0), 32'h0);
        chk("reset_state", 32'(st0), 32'h0);
`ifdef MEM_BUS_BUSERR_EN
        chk("reset_buserr", 32'(berr0), 32'h0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus_txn(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp, 1'b0, got, lat);
            chk($sformatf("led_v%0d", i), 32'(led0), 32'(vecs[i].exp_led));
        end

        // Cycle counter: reads 10 idle cycles apart differ by 13.
        bus_txn(1'b0, 1'b1, 1'b0, 32'h0000F004, 32'h0, 32'h0, 1'b1, r1, lat);
        repeat (10) @(negedge clk);
        bus_txn(1'b0, 1'b1, 1'b0, 32'h0000F004, 32'h0, 32'h0, 1'b1, r2, lat);
        chk("cnt_delta", r2 - r1, 32'd13);
        // Back-to-back: delta of 3.
        bus_txn(1'b0, 1'b1, 1'b0, 32'h0000F004, 32'h0, 32'h0, 1'b1, r1, lat);
        bus_txn(1'b0, 1'b1, 1'b0, 32'h0000F004, 32'h0, 32'h0, 1'b1, r2, lat);
        chk("cnt_b2b_delta", r2 - r1, 32'd3);

`ifdef MEM_BUS_BUSERR_EN
        bus_txn(1'b0, 1'b0, 1'b1, 32'h0000F008, 32'h0, 32'h0, 1'b0, got, lat);
        chk("buserr_clear0", 32'(berr0), 32'h0);
        bus_txn(1'b0, 1'b1, 1'b0, 32'h00008000, 32'h0, 32'h0, 1'b0, got, lat);
        chk("buserr_set", 32'(berr0), 32'h1);
        bus_txn(1'b0, 1'b1, 1'b0, 32'h0000F008, 32'h0, 32'h00008001, 1'b0, got, lat);
        bus_txn(1'b0, 1'b0, 1'b1, 32'h0000F008, 32'h12345678, 32'h0, 1'b0, got, lat);
        chk("buserr_clear", 32'(berr0), 32'h0);
        bus_txn(1'b0, 1'b1, 1'b0, 32'h0000F008, 32'h0, 32'h0, 1'b0, got, lat);
`else
        bus_txn(1'b0, 1'b0, 1'b1, 32'h0000F008, 32'hFFFFFFFF, 32'h0, 1'b0, got, lat);
        bus_txn(1'b0, 1'b1, 1'b0, 32'h0000F008, 32'h0, 32'h0, 1'b0, got, lat);
`endif

        // Wait-state instance, then reset during ACCESS.
        bus_txn(1'b1, 1'b0, 1'b1, 32'h00000000, 32'hCAFEF00D, 32'h0, 1'b0, got, lat);
        bus_txn(1'b1, 1'b1, 1'b0, 32'h00000000, 32'h0, 32'hCAFEF00D, 1'b0, got, lat);
        bus_txn(1'b1, 1'b0, 1'b1, 32'h00000008, 32'h00002222, 32'h0, 1'b0, got, lat);
        abort_txn(1'b0, 1'b1, 32'h00000008, 32'h33333333, 1);
        chk("led_after_reset", 32'(led0), 32'h0);
        bus_txn(1'b1, 1'b1, 1'b0, 32'h00000008, 32'h0, 32'h00002222, 1'b0, got, lat);
        abort_txn(1'b0, 1'b1, 32'h00000004, 32'h11111111, 2);
        bus_txn(1'b1, 1'b1, 1'b0, 32'h00000004, 32'h0, 32'h11111111, 1'b0, got, lat);
        abort_txn(1'b1, 1'b0, 32'h00000000, 32'h0, 2);
        bus_txn(1'b1, 1'b1, 1'b0, 32'h00000000, 32'h0, 32'hCAFEF00D, 1'b0, got, lat);
        bus_txn(1'b0, 1'b1, 1'b0, 32'h00003FFC, 32'h0, 32'hDEADBEEF, 1'b0, got, lat);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Memory/bus controller directly downstream of the CPU memory port.
- Consumes the CPU's address, write-data, read and write strobes; returns read data plus a ready handshake.
- Owns a word-addressed synchronous RAM (instruction and data) and a small MMIO page: LED register and free-running cycle counter.
- Replaces the combinational bench memory model with a registered, wait-state-capable bus.

Parameters:
- ADDR_W, 12: RAM word-address width; RAM covers bytes 0x0 to (4*2^ADDR_W - 1), i.e. 0x0000-0x3FFF at default.
- MMIO_BASE, 32'h0000F000: base byte address of the 4 KB MMIO page.
- WAIT_STATES, 0: extra ACCESS cycles inserted before DONE (0-15).

Ports:
- iClk  in  1  system clock, rising edge.
- nRst  in  1  asynchronous active-low reset.
- iMemAddr  in  32  byte address from CPU; bits [1:0] ignored (word access only).
- iMemData  in  32  write data from CPU.
- oMemData  out  32  read data to CPU; valid only while oMemReady=1.
- iMemRead  in  1  read request, held by CPU until ready.
- iMemWrite  in  1  write request, held by CPU until ready.
- oMemReady  out  1  one-cycle completion pulse.
- oLed  out  8  LED register contents.

Behaviour:
- Clock and reset: one clock (iClk); reset is asynchronous and active-low (nRst).
- Reset values: oMemData=0, oMemReady=0, oLed=0, cycle counter=0, FSM=IDLE, wait counter=0. RAM contents are not reset.
- Reset asserted mid-transaction aborts it immediately. An in-flight write already committed in ACCESS stays written; otherwise it is dropped.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If iMemWrite or iMemRead is sampled high, latch address, write data and operation type, then go to ACCESS.
  - Write has priority when both strobes are high; the read is ignored.
- ACCESS:
  - First cycle: the RAM write is committed, or the RAM/MMIO read is issued.
  - Stays in ACCESS for WAIT_STATES additional cycles using a down-counter.
  - Then goes to DONE.
- DONE:
  - oMemReady=1 for exactly one cycle; oMemData holds the registered read data (0 for writes).
  - Unconditionally returns to IDLE.
- Latency: request sampled at edge N gives oMemReady high during cycle N+2+WAIT_STATES.
- Handshake rule: the CPU must drop or change its request on the edge after ready. A request still high in IDLE is treated as a new transaction.
- Address decode (uses the latched address):
  - RAM when addr < 4*2^ADDR_W; index = addr[ADDR_W+1:2].
  - MMIO page when addr[31:12] == MMIO_BASE[31:12].
    - +0x0: LED, R/W. Write takes iMemData[7:0]; read returns {24'b0, oLed}.
    - +0x4: cycle counter, RO. Writes are ignored.
  - Anything else is unmapped: read returns 0, write is discarded. Ready is still pulsed so the bus never hangs.
- Cycle counter:
  - 32-bit, increments every cycle out of reset and wraps 0xFFFFFFFF to 0.
  - Read value is the count sampled in the first ACCESS cycle.
- Back-to-back: minimum 3 cycles per transaction at WAIT_STATES=0; no pipelining of requests.
- Read of a RAM word written by the immediately preceding transaction returns the new data.

Optional Feature:
- Macro: MEM_BUS_BUSERR_EN.
- Enabled:
  - Adds output oBusErr (1 bit) and a sticky error register at MMIO_BASE+0x8.
  - Any unmapped access sets the sticky bit (bit0) and latches the offending address in bits [31:2], bits [1:0] reading as 1'b0,1'b1.
  - oBusErr = sticky bit.
  - Writing any value to +0x8 clears it; the register resets to 0.
- Disabled: no oBusErr port; +0x8 is unmapped; unmapped accesses leave no trace.

Test Plan:
- Reset then RAM writes: write 0x00000002 to 0x1000, then 0x00000001 to 0x1004. Reads of 0x1000/0x1004 return 2/1 with ready in cycle N+2.
- LED: write 0xA5A5A5A5 to 0xF000 -> oLed=0xA5 from the DONE cycle onward. Read 0xF000 -> 0x000000A5.
- Cycle counter: two reads of 0xF004 separated by 10 idle cycles differ by exactly 13 (3-cycle transaction + 10 idle) at WAIT_STATES=0.
- WAIT_STATES=3: read of 0x0 is ready on cycle N+5. Assert nRst low during ACCESS -> oMemReady stays 0 and the FSM is in IDLE on release.
- Simultaneous iMemRead=iMemWrite=1 at 0x8 with data 0x12345678 -> write performed; subsequent read of 0x8 returns 0x12345678.
- Unmapped read at 0x8000 -> data 0, ready pulses. With MEM_BUS_BUSERR_EN, oBusErr=1 and a read of 0xF008 returns 0x00008001; writing 0xF008 clears oBusErr.
